// File: rtl/spike_rate_decoder.sv
// Spike train to rate decoder: counts spike rising edges over a
// 2**WIN_LOG2 cycle window and offers the saturated count on valid/ready.
module spike_rate_decoder #(
  parameter int WIN_LOG2 = 8,
  parameter int WIDTH    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike,
  output logic [WIDTH-1:0] rate,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic {
    S_IDLE,
    S_COUNT
  } state_t;

  localparam logic [WIN_LOG2-1:0] WIN_ONE = 1;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIN_LOG2-1:0] r_win_cnt;
  logic [WIDTH-1:0]    r_spk_cnt;
  logic                r_spike_q;
  logic [WIDTH-1:0]    r_rate;
  logic                r_rate_valid;
  logic                r_overrun;

  logic             w_edge;
  logic             w_count;
  logic             w_last;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_result;
  logic             w_load;
  logic             w_drop;
  logic             w_xfer;

  assign w_edge   = spike & ~r_spike_q;
  assign w_count  = (r_state == S_COUNT);
  assign w_last   = w_count & (&r_win_cnt);
  // Hold at all-ones instead of wrapping to zero.
  assign w_inc    = {{(WIDTH-1){1'b0}}, w_edge & ~(&r_spk_cnt)};
  assign w_result = r_spk_cnt + w_inc;
  assign w_load   = w_last & (~r_rate_valid | rate_ready);
  assign w_drop   = w_last & r_rate_valid & ~rate_ready;
  assign w_xfer   = r_rate_valid & rate_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (en) w_state_nxt = S_COUNT;
      end
      S_COUNT: begin
        if (!en) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_spike_q    <= 1'b0;
      r_win_cnt    <= '0;
      r_spk_cnt    <= '0;
      r_rate       <= '0;
      r_rate_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_spike_q <= spike;
      // Counters only advance inside a live window; abort or end clears them.
      if (w_count && en && !w_last) begin
        r_win_cnt <= r_win_cnt + WIN_ONE;
        r_spk_cnt <= w_result;
      end else begin
        r_win_cnt <= '0;
        r_spk_cnt <= '0;
      end
      if (w_load) begin
        r_rate       <= w_result;
        r_rate_valid <= 1'b1;
      end else if (w_xfer) begin
        r_rate_valid <= 1'b0;
      end
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  assign rate       = r_rate;
  assign rate_valid = r_rate_valid;
  assign overrun    = r_overrun;
  assign busy       = w_count;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: scoreboarded rate transfers plus
// directed checks on busy, latency, backpressure and saturation.
module tb_spike_rate_decoder;

  logic       clk;
  logic       rst;
  logic       en;
  logic       spike;
  logic [7:0] rate;
  logic       rate_valid;
  logic       rate_ready;
  logic       overrun;
  logic       busy;

  logic       s_en;
  logic       s_spike;
  logic [7:0] s_rate;
  logic       s_valid;
  logic       s_ready;
  logic       s_overrun;
  logic       s_busy;

  int n_vec;
  int n_err;
  int q[$];

  spike_rate_decoder #(.WIN_LOG2(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .spike     (spike),
    .rate      (rate),
    .rate_valid(rate_valid),
    .rate_ready(rate_ready),
    .overrun   (overrun),
    .busy      (busy)
  );

  spike_rate_decoder #(.WIN_LOG2(10), .WIDTH(8)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .en        (s_en),
    .spike     (s_spike),
    .rate      (s_rate),
    .rate_valid(s_valid),
    .rate_ready(s_ready),
    .overrun   (s_overrun),
    .busy      (s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rate_valid && rate_ready) begin
      if (q.size() == 0) begin
        check("sb_unexpected", {24'd0, rate}, 32'hFFFF_FFFF);
      end else begin
        check("sb_rate", {24'd0, rate}, q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_window(input logic [16:0] sp,
                           input logic rdy,
                           input bit lat);
    rate_ready = rdy;
    for (int k = 0; k <= 16; k++) begin
      en    = 1'b1;
      spike = sp[k];
      step();
      if (k == 0 || k == 16) check("busy_on", {31'd0, busy}, 1);
      if (lat && k == 15) check("valid_early", {31'd0, rate_valid}, 0);
      if (lat && k == 16) check("valid_rise", {31'd0, rate_valid}, 1);
    end
    en    = 1'b0;
    spike = 1'b0;
    step();
    check("busy_off", {31'd0, busy}, 0);
    if (lat) check("valid_one_cyc", {31'd0, rate_valid}, 0);
    step();
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b1;
    en         = 1'b1;
    spike      = 1'b0;
    rate_ready = 1'b1;
    s_en       = 1'b0;
    s_spike    = 1'b0;
    s_ready    = 1'b1;

    for (int i = 0; i < 3; i++) begin
      spike = ~spike;
      step();
    end
    rst   = 1'b0;
    en    = 1'b0;
    spike = 1'b0;
    check("rst_rate", {24'd0, rate}, 0);
    check("rst_valid", {31'd0, rate_valid}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    step();
    check("idle_busy", {31'd0, busy}, 0);

    q.push_back(4);
    do_window(17'h04444, 1'b1, 1'b1);

    spike = 1'b1;
    step();
    q.push_back(0);
    do_window(17'h1FFFF, 1'b1, 1'b1);
    q.push_back(1);
    do_window(17'h1FFDF, 1'b1, 1'b1);

    q.push_back(3);
    do_window(17'h00054, 1'b0, 1'b0);
    check("bp1_valid", {31'd0, rate_valid}, 1);
    check("bp1_rate", {24'd0, rate}, 3);
    check("bp1_overrun", {31'd0, overrun}, 0);
    do_window(17'h02AAA, 1'b0, 1'b0);
    check("bp2_valid", {31'd0, rate_valid}, 1);
    check("bp2_rate", {24'd0, rate}, 3);
    check("bp2_overrun", {31'd0, overrun}, 1);
    rate_ready = 1'b1;
    step();
    check("bp_drain_valid", {31'd0, rate_valid}, 0);
    check("bp_sticky", {31'd0, overrun}, 1);

    rate_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      en    = (k < 8);
      spike = k[0];
      step();
      if (k == 1) check("abort_busy_on", {31'd0, busy}, 1);
      if (k == 8) check("abort_busy_off", {31'd0, busy}, 0);
    end
    spike = 1'b0;
    for (int k = 0; k < 20; k++) step();
    check("abort_no_valid", {31'd0, rate_valid}, 0);
    q.push_back(1);
    do_window(17'h10000, 1'b1, 1'b1);

    for (int k = 0; k <= 1024; k++) begin
      s_en    = 1'b1;
      s_spike = k[0];
      step();
      if (k == 1023) check("sat_early", {31'd0, s_valid}, 0);
      if (k == 1024) begin
        check("sat_valid", {31'd0, s_valid}, 1);
        check("sat_rate", {24'd0, s_rate}, 255);
      end
    end
    s_en    = 1'b0;
    s_spike = 1'b0;
    step();
    step();

    check("sb_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
